// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic operand feeder: FSM encoding and the
// MSB-first lane packing used by both the feeder and the array.
package systolic_feeder_pkg;

  // Feeder control states. The encoding is also exported on dbg_state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } feeder_state_t;

  localparam int STATE_W = 2;

  // LSB position of lane idx in a bus of `lanes` elements of `width` bits,
  // with element 0 occupying the most-significant slot.
  function automatic int lane_lsb(input int lanes, input int idx, input int width);
    return (lanes - 1 - idx) * width;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// One skew lane: DEPTH zero-reset delay stages followed by an output register.
// DEPTH = 0 degenerates to a single output register.
module skew_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] tail;

  generate
    if (DEPTH == 0) begin : g_direct
      assign tail = din;
    end else begin : g_chain
      logic [WIDTH-1:0] stage [DEPTH];

      // Delay chain: each stage adds one cycle of skew.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else begin
          stage[0] <= din;
          for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
      end

      assign tail = stage[DEPTH-1];
    end
  endgenerate

  // Output register driving the array edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= tail;
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand stager for the systolic array. Takes one K-slice per beat (A column,
// B row), skews lane i/j by i/j cycles, zero-fills idle cycles, and pulses
// done once the last operand has reached the far corner of the array.
//
// Handshake: a beat transfers on a rising edge where in_valid and in_ready are
// both high. in_ready is high for the whole LOAD state and depends only on
// state; in_valid may be raised or dropped freely, and a cycle without a
// transfer injects an all-zero bubble into the skew lines.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int I     = 4,
  parameter int J     = 4,
  parameter int KW    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [KW-1:0]      k_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [I*WIDTH-1:0] a_vec,
  input  logic [J*WIDTH-1:0] b_vec,
  output logic [I*WIDTH-1:0] out_west,
  output logic [J*WIDTH-1:0] out_north,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] dbg_state
);

  // Drain counter must hold I+J-1.
  localparam int DW = $clog2(I + J);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(I + J - 1);

  feeder_state_t state, state_next;
  logic [KW-1:0] beat_cnt, beat_next;
  logic [DW-1:0] drain_cnt, drain_next;

  logic               accept;
  logic [I*WIDTH-1:0] a_in;
  logic [J*WIDTH-1:0] b_in;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      beat_cnt  <= beat_next;
      drain_cnt <= drain_next;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_next = state;
    beat_next  = beat_cnt;
    drain_next = drain_cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            state_next = ST_LOAD;
            beat_next  = k_len;
          end else begin
            // Empty pass: go straight to the done cycle.
            state_next = ST_DRAIN;
            drain_next = '0;
          end
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          beat_next = beat_cnt - KW'(1);
          if (beat_cnt == KW'(1)) begin
            state_next = ST_DRAIN;
            drain_next = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == '0) state_next = ST_IDLE;
        else                 drain_next = drain_cnt - DW'(1);
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    dbg_state = state;
    case (state)
      ST_LOAD:  begin in_ready = 1'b1; busy = 1'b1; end
      ST_DRAIN: begin busy = 1'b1; done = (drain_cnt == '0); end
      default:  begin end
    endcase
  end

  assign accept = in_valid & in_ready;

  // Non-transfer cycles feed zeros so the array accumulates nothing.
  always_comb begin
    a_in = '0;
    b_in = '0;
    if (accept) begin
      a_in = a_vec;
      b_in = b_vec;
    end
  end

  // West edge: lane i delayed by i cycles.
  generate
    for (genvar gi = 0; gi < I; gi++) begin : g_west
      skew_line #(.WIDTH(WIDTH), .DEPTH(gi)) u_line (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (a_in[lane_lsb(I, gi, WIDTH) +: WIDTH]),
        .dout (out_west[lane_lsb(I, gi, WIDTH) +: WIDTH])
      );
    end
    // North edge: lane j delayed by j cycles.
    for (genvar gj = 0; gj < J; gj++) begin : g_north
      skew_line #(.WIDTH(WIDTH), .DEPTH(gj)) u_line (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (b_in[lane_lsb(J, gj, WIDTH) +: WIDTH]),
        .dout (out_north[lane_lsb(J, gj, WIDTH) +: WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: per-lane scoreboard of skewed operands, done/busy
// timing checks, and an end-to-end run through a behavioural output-stationary
// array compared with a direct matrix product.
module tb_systolic_feeder;

  localparam int WIDTH = 16;
  localparam int I     = 4;
  localparam int J     = 4;
  localparam int KW    = 8;
  localparam int EW    = 32 + 1 + 8 + WIDTH;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [KW-1:0]      k_len = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [I*WIDTH-1:0] a_vec = '0;
  logic [J*WIDTH-1:0] b_vec = '0;
  logic [I*WIDTH-1:0] out_west;
  logic [J*WIDTH-1:0] out_north;
  logic               busy;
  logic               done;
  logic [1:0]         dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_cnt = 0;
  int ready_cnt = 0;
  bit mon_en = 1'b1;

  // Expected entry: {due cycle, north flag, lane, value}
  logic [EW-1:0] exp_q[$];
  logic [I*WIDTH-1:0] exp_w;
  logic [J*WIDTH-1:0] exp_n;

  systolic_feeder #(.WIDTH(WIDTH), .I(I), .J(J), .KW(KW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_vec    (a_vec),
    .b_vec    (b_vec),
    .out_west (out_west),
    .out_north(out_north),
    .busy     (busy),
    .done     (done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural array (output stationary) ----------------
  logic [WIDTH-1:0] pa [I][J];
  logic [WIDTH-1:0] pb [I][J];
  int               acc [I][J];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < I; r++)
        for (int c = 0; c < J; c++) begin
          pa[r][c] <= '0; pb[r][c] <= '0; acc[r][c] <= 0;
        end
    end else begin
      for (int r = 0; r < I; r++)
        for (int c = 0; c < J; c++) begin
          logic [WIDTH-1:0] ain, bin;
          ain = (c == 0) ? out_west[(I-1-r)*WIDTH +: WIDTH] : pa[r][c-1];
          bin = (r == 0) ? out_north[(J-1-c)*WIDTH +: WIDTH] : pb[r-1][c];
          pa[r][c]  <= ain;
          pb[r][c]  <= bin;
          acc[r][c] <= acc[r][c] + int'(ain) * int'(bin);
        end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (in_valid && in_ready) begin
      last_acc = cyc;
      for (int i = 0; i < I; i++)
        exp_q.push_back({32'(cyc + 1 + i), 1'b0, 8'(i), a_vec[(I-1-i)*WIDTH +: WIDTH]});
      for (int j = 0; j < J; j++)
        exp_q.push_back({32'(cyc + 1 + j), 1'b1, 8'(j), b_vec[(J-1-j)*WIDTH +: WIDTH]});
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    if (in_ready) ready_cnt++;
    if (mon_en) begin
      exp_w = '0;
      exp_n = '0;
      for (int e = exp_q.size() - 1; e >= 0; e--) begin
        if (exp_q[e][EW-1 -: 32] == 32'(cyc)) begin
          if (exp_q[e][WIDTH+8])
            exp_n[(J-1-int'(exp_q[e][WIDTH +: 8]))*WIDTH +: WIDTH] = exp_q[e][WIDTH-1:0];
          else
            exp_w[(I-1-int'(exp_q[e][WIDTH +: 8]))*WIDTH +: WIDTH] = exp_q[e][WIDTH-1:0];
          exp_q.delete(e);
        end
      end
      checks++;
      if (out_west !== exp_w) begin
        errors++;
        $display("FAIL west_lanes cyc=%0d got=%h exp=%h", cyc, out_west, exp_w);
      end
      checks++;
      if (out_north !== exp_n) begin
        errors++;
        $display("FAIL north_lanes cyc=%0d got=%h exp=%h", cyc, out_north, exp_n);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int k);
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
    k_len = '0;
  endtask

  task automatic send_beat(input logic [I*WIDTH-1:0] a, input logic [J*WIDTH-1:0] b);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_for_beat cyc=%0d got=%b exp=1", cyc, in_ready);
    end
    in_valid = 1'b1;
    a_vec    = a;
    b_vec    = b;
    tick();
    in_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
  endtask

  task automatic rand_beat(output logic [I*WIDTH-1:0] a, output logic [J*WIDTH-1:0] b);
    for (int i = 0; i < I; i++) a[(I-1-i)*WIDTH +: WIDTH] = WIDTH'($urandom_range(1, 16'hffff));
    for (int j = 0; j < J; j++) b[(J-1-j)*WIDTH +: WIDTH] = WIDTH'($urandom_range(1, 16'hffff));
  endtask

  task automatic wait_done(input int budget, input string name);
    int  base;
    bit  seen;
    base = done_cnt;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      tick();
      if (done_cnt != base) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout got=no_done exp=done_within_%0d", name, budget);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [I*WIDTH-1:0] a;
    logic [J*WIDTH-1:0] b;
    int dbase;
    apply_reset();
    checks++;
    if ({out_west, out_north, in_ready, busy, done, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h/%h/%b%b%b/%0d exp=0", out_west, out_north, in_ready, busy, done, dbg_state);
    end
    // Abandon a pass after 2 of 4 beats.
    dbase = done_cnt;
    pulse_start(4);
    rand_beat(a, b); send_beat(a, b);
    rand_beat(a, b); send_beat(a, b);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({out_west, out_north, in_ready, busy, done, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_mid_load got=%h/%h/%b%b%b/%0d exp=0", out_west, out_north, in_ready, busy, done, dbg_state);
    end
    tick(); tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checks++;
    if (done_cnt != dbase) begin
      errors++;
      $display("FAIL reset_no_done got=%0d exp=%0d", done_cnt - dbase, 0);
    end
    // Fresh pass completes normally.
    pulse_start(1);
    rand_beat(a, b); send_beat(a, b);
    wait_done(20, "reset_recover");
    checks++;
    if (done_cyc != last_acc + I + J) begin
      errors++;
      $display("FAIL reset_recover_done_cyc got=%0d exp=%0d", done_cyc, last_acc + I + J);
    end
    tick();
  endtask

  task automatic test_single_beat();
    int rbase;
    rbase = ready_cnt;
    pulse_start(1);
    send_beat({16'd1, 16'd2, 16'd3, 16'd4}, {16'd5, 16'd6, 16'd7, 16'd8});
    wait_done(20, "single");
    checks++;
    if (done_cyc != last_acc + 8) begin
      errors++;
      $display("FAIL single_done_cyc got=%0d exp=%0d", done_cyc, last_acc + 8);
    end
    checks++;
    if (ready_cnt - rbase != 1) begin
      errors++;
      $display("FAIL single_ready_cycles got=%0d exp=1", ready_cnt - rbase);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [I*WIDTH-1:0] a;
    logic [J*WIDTH-1:0] b;
    int first, rbase;
    rbase = ready_cnt;
    pulse_start(3);
    rand_beat(a, b); send_beat(a, b);
    first = last_acc;
    rand_beat(a, b); send_beat(a, b);
    rand_beat(a, b); send_beat(a, b);
    checks++;
    if (last_acc - first != 2) begin
      errors++;
      $display("FAIL b2b_throughput got=%0d exp=2", last_acc - first);
    end
    wait_done(20, "b2b");
    checks++;
    if (done_cyc != last_acc + I + J) begin
      errors++;
      $display("FAIL b2b_done_cyc got=%0d exp=%0d", done_cyc, last_acc + I + J);
    end
    checks++;
    if (ready_cnt - rbase != 3) begin
      errors++;
      $display("FAIL b2b_ready_cycles got=%0d exp=3", ready_cnt - rbase);
    end
    tick();
  endtask

  task automatic test_gap();
    logic [I*WIDTH-1:0] a;
    logic [J*WIDTH-1:0] b;
    int first;
    pulse_start(3);
    rand_beat(a, b); send_beat(a, b);
    first = last_acc;
    tick(); tick();
    rand_beat(a, b); send_beat(a, b);
    rand_beat(a, b); send_beat(a, b);
    checks++;
    if (last_acc - first != 4) begin
      errors++;
      $display("FAIL gap_last_accept got=%0d exp=4", last_acc - first);
    end
    wait_done(20, "gap");
    checks++;
    if (done_cyc != first + 4 + I + J) begin
      errors++;
      $display("FAIL gap_done_cyc got=%0d exp=%0d", done_cyc, first + 4 + I + J);
    end
    tick();
  endtask

  task automatic test_zero_len();
    int s, bbase, rbase;
    bbase = busy_cnt;
    rbase = ready_cnt;
    s = cyc;
    pulse_start(0);
    wait_done(5, "zero");
    tick();
    checks++;
    if (done_cyc != s + 1) begin
      errors++;
      $display("FAIL zero_done_cyc got=%0d exp=%0d", done_cyc, s + 1);
    end
    checks++;
    if (busy_cnt - bbase != 1) begin
      errors++;
      $display("FAIL zero_busy_cycles got=%0d exp=1", busy_cnt - bbase);
    end
    checks++;
    if (ready_cnt - rbase != 0) begin
      errors++;
      $display("FAIL zero_ready_cycles got=%0d exp=0", ready_cnt - rbase);
    end
  endtask

  task automatic test_start_in_drain();
    logic [I*WIDTH-1:0] a;
    logic [J*WIDTH-1:0] b;
    int dbase, rbase;
    dbase = done_cnt;
    rbase = ready_cnt;
    pulse_start(1);
    rand_beat(a, b); send_beat(a, b);
    tick(); tick();
    pulse_start(2);
    wait_done(20, "drain_start");
    checks++;
    if (done_cyc != last_acc + I + J) begin
      errors++;
      $display("FAIL drain_start_done_cyc got=%0d exp=%0d", done_cyc, last_acc + I + J);
    end
    repeat (12) tick();
    checks++;
    if (done_cnt - dbase != 1) begin
      errors++;
      $display("FAIL drain_start_done_count got=%0d exp=1", done_cnt - dbase);
    end
    checks++;
    if (busy !== 1'b0 || ready_cnt - rbase != 1) begin
      errors++;
      $display("FAIL drain_start_ignored got=busy%b_ready%0d exp=busy0_ready1", busy, ready_cnt - rbase);
    end
  endtask

  task automatic test_array_e2e();
    int ma [I][4];
    int mb [4][J];
    int ref_v;
    logic [I*WIDTH-1:0] a;
    logic [J*WIDTH-1:0] b;
    apply_reset();
    for (int i = 0; i < I; i++) for (int k = 0; k < 4; k++) ma[i][k] = int'($urandom_range(0, 15));
    for (int k = 0; k < 4; k++) for (int j = 0; j < J; j++) mb[k][j] = int'($urandom_range(0, 15));
    pulse_start(4);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < I; i++) a[(I-1-i)*WIDTH +: WIDTH] = WIDTH'(ma[i][k]);
      for (int j = 0; j < J; j++) b[(J-1-j)*WIDTH +: WIDTH] = WIDTH'(mb[k][j]);
      send_beat(a, b);
    end
    wait_done(20, "e2e");
    tick();
    for (int i = 0; i < I; i++)
      for (int j = 0; j < J; j++) begin
        ref_v = 0;
        for (int k = 0; k < 4; k++) ref_v += ma[i][k] * mb[k][j];
        checks++;
        if (acc[i][j] != ref_v) begin
          errors++;
          $display("FAIL e2e_c%0d%0d got=%0d exp=%0d", i, j, acc[i][j], ref_v);
        end
      end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_gap();
    test_zero_len();
    test_start_in_drain();
    test_array_e2e();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
